ifetch_queue: RTL
=================

// Module: ifetch_queue
// PURPOSE
//   Instruction-fetch stage directly downstream of the program counter.
//   - Issues fetches for the PC's current address to instruction memory over a
//     req/gnt + rvalid bus.
//   - Pairs each returned word with its PC and buffers the pair in a DEPTH-entry
//     queue toward decode (valid/ready).
//   - Tells the PC when to advance (pc_step).
//   - Discards stale work on a redirect (flush).
// PARAMETERS
//   DEPTH   4   Queue entries and maximum outstanding fetches. Power of two, >=2.
//   AW      32  Address/instruction width.
// PORTS
//   clk          in   1   Clock, rising edge.
//   rst          in   1   Synchronous reset, active-high.
//   pc_addr      in   AW  Current PC (the PC's addr output).
//   pc_step      out  1   1 = fetch for pc_addr accepted this cycle; PC advances only then.
//   flush        in   1   Redirect (taken branch/jump); drop everything older.
//   imem_req     out  1   Fetch request.
//   imem_addr    out  AW  Fetch address (= pc_addr).
//   imem_gnt     in   1   Request accepted when imem_req & imem_gnt.
//   imem_rvalid  in   1   Response valid; responses return in order, one per grant, >=1 cycle after it.
//   imem_rdata   in   AW  Response instruction word.
//   inst_valid   out  1   Decode-side valid.
//   inst_data    out  AW  Instruction word.
//   inst_pc      out  AW  PC of inst_data.
//   inst_ready   in   1   Decode accepts when inst_valid & inst_ready.
// BEHAVIOUR
//   - Reset: all outputs and state are 0; queues are empty; outst = 0; drop = 0; FSM = RUN.
//   - Counters: outst (granted, not returned, not dropped) and drop are $clog2(DEPTH)+1 bits.
//   - Issue:
//     - imem_req = !flush & (outst + q_count < DEPTH).
//     - imem_addr = pc_addr.
//     - pc_step = imem_req & imem_gnt.
//     - On a grant, pc_addr is pushed into the tag FIFO (DEPTH entries).
//   - Return, in FSM state RUN: on rvalid, pop tag FIFO -> push {tag, rdata} into the output queue.
//     - Default latency: rvalid at edge N -> inst_valid visible after edge N.
//   - Output:
//     - inst_valid = q_count != 0 & !flush.
//     - The head is popped on inst_valid & inst_ready.
//     - A push and a pop in the same cycle leave q_count unchanged.
//     - The credit rule guarantees the queue never overflows.
//   - Flush (has priority over every other event that cycle):
//     - Output queue and tag FIFO are cleared.
//     - No handshake completes; no grant is taken.
//     - drop <= outst - imem_rvalid.
//     - outst <= 0.
//     - FSM -> DROP if that drop value != 0.
//   - FSM state DROP:
//     - Each rvalid decrements drop and discards rdata.
//     - At drop == 1 with rvalid, go to RUN.
//     - New requests may issue during DROP; their responses follow the dropped ones.
//   - Flush while in DROP: drop <= drop + outst - imem_rvalid (accumulates).
//   - rvalid with outst == 0 and state RUN: protocol error; ignored, no state change.
//   - Wrap-around: FIFO pointers are log2(DEPTH) bits and wrap naturally; full/empty come from the counts.
//   - Reset asserted mid-operation: everything returns to reset values at that edge.
//     - Responses to pre-reset requests are then treated as protocol errors; memory must be reset together with this block.
// CONFIGURATION
//   IFETCH_BYPASS_EN
//     - Defined: when the output queue is empty, rvalid is in RUN, and flush = 0,
//       {tag, rdata} drive inst_* combinationally in the same cycle
//       (inst_valid = 1, zero-cycle latency).
//     - If inst_ready is also 1, the word is consumed and not queued; otherwise it is queued.
//     - Undefined: no combinational path from imem_* to inst_*; the word always appears one cycle later.
// TESTING
//   1. Reset, gnt=1, ready=1, rdata=addr^32'hFFFF_FFFF, latency 1, PC from 0 stepping +4
//      -> inst_pc 0,4,8,... in order; inst_data matches; pc_step high every cycle after the pipe fills.
//   2. ready=0, gnt=1 -> exactly DEPTH=4 grants (addr 0..C), then imem_req=0.
//      Then ready=1 -> 4 words drain in order and issue resumes at 0x10.
//   3. 2 requests outstanding (0x20, 0x24), flush with target 0x100
//      -> both responses dropped; first inst_pc after flush = 0x100.
//   4. flush in the same cycle as rvalid and inst_ready with q_count=1
//      -> no handshake; queue empty; drop = outst-1; nothing stale emitted.
//   5. gnt toggling 1,0,1 and response latency 3
//      -> pc_step only on granted cycles; no duplicate or missing PC.
//   6. Queue empty, rvalid and ready at the same edge:
//      IFETCH_BYPASS_EN defined -> inst_valid in that cycle;
//      undefined -> inst_valid the next cycle.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: issues fetches for the PC, pairs responses with their PC and
// queues them toward decode. Optional macro IFETCH_BYPASS_EN adds a zero-latency path.
module ifetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc_addr,
   output logic          pc_step,
   input  logic          flush,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_gnt,
   input  logic          imem_rvalid,
   input  logic [AW-1:0] imem_rdata,
   output logic          inst_valid,
   output logic [AW-1:0] inst_data,
   output logic [AW-1:0] inst_pc,
   input  logic          inst_ready
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef enum logic {RUN = 1'b0, DROP = 1'b1} state_t;

   state_t        state;
   logic [CW-1:0] drop;

   logic [AW-1:0] tag_mem [DEPTH];
   logic [PW-1:0] tag_wr;
   logic [PW-1:0] tag_rd;
   logic [CW-1:0] outst;

   logic [AW-1:0] q_data [DEPTH];
   logic [AW-1:0] q_pc   [DEPTH];
   logic [PW-1:0] q_wr;
   logic [PW-1:0] q_rd;
   logic [CW-1:0] q_count;

   logic          live;
   logic [CW:0]   inflight;
   logic          grant;
   logic          rv_run;
   logic          rv_drop;
   logic          q_empty;
   logic          push;
   logic          pop;
   logic [AW-1:0] tag_head;
   logic [CW-1:0] drop_base;
   logic [CW-1:0] drop_flush;

   // Reset and flush both suppress every handshake in the current cycle.
   assign live     = !rst && !flush;
   assign inflight = {1'b0, outst} + {1'b0, q_count};
   assign imem_req = live && (inflight < DEPTH_W);
   assign imem_addr = pc_addr;
   assign grant    = imem_req && imem_gnt;
   assign pc_step  = grant;

   assign tag_head = tag_mem[tag_rd];
   assign q_empty  = (q_count == '0);

   // A response with nothing outstanding in RUN is a protocol error and is ignored.
   assign rv_run  = live && imem_rvalid && (state == RUN) && (outst != '0);
   assign rv_drop = live && imem_rvalid && (state == DROP);

`ifdef IFETCH_BYPASS_EN
   logic byp;
   assign byp  = rv_run && q_empty;
   assign push = rv_run && !(byp && inst_ready);
`else
   assign push = rv_run;
`endif

   always_comb begin
      inst_valid = live && !q_empty;
      inst_data  = '0;
      inst_pc    = '0;
      if (inst_valid) begin
         inst_data = q_data[q_rd];
         inst_pc   = q_pc[q_rd];
      end
`ifdef IFETCH_BYPASS_EN
      if (byp) begin
         inst_valid = 1'b1;
         inst_data  = imem_rdata;
         inst_pc    = tag_head;
      end
`endif
   end

   assign pop = inst_valid && inst_ready && !q_empty;

   // Responses still owed to already-flushed fetches, minus one arriving right now.
   assign drop_base  = ((state == DROP) ? drop : '0) + outst;
   assign drop_flush = drop_base - CW'(imem_rvalid && (drop_base != '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         drop  <= '0;
      end else if (flush) begin
         drop  <= drop_flush;
         state <= (drop_flush != '0) ? DROP : RUN;
      end else if (rv_drop) begin
         drop <= drop - CW'(1);
         if (drop == CW'(1))
            state <= RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         tag_wr <= '0;
         tag_rd <= '0;
         outst  <= '0;
      end else begin
         if (grant)
            tag_wr <= tag_wr + PW'(1);
         if (rv_run)
            tag_rd <= tag_rd + PW'(1);
         outst <= outst + CW'(grant) - CW'(rv_run);
      end
   end

   always_ff @(posedge clk) begin
      if (grant)
         tag_mem[tag_wr] <= pc_addr;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         q_wr    <= '0;
         q_rd    <= '0;
         q_count <= '0;
      end else begin
         if (push)
            q_wr <= q_wr + PW'(1);
         if (pop)
            q_rd <= q_rd + PW'(1);
         q_count <= q_count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_data[q_wr] <= imem_rdata;
         q_pc[q_wr]   <= tag_head;
      end
   end

endmodule
